// File: rtl/pipelined_adder.sv
// Pipelined chunked adder/subtractor: one CHUNK-bit slice is summed per stage and the
// carry is registered between stages, with a valid/ready handshake on both ends.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_carry;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [CHUNK:0]    slice;

    // Handshake: a transfer happens on a clock edge where valid && ready are both high.
    // Stage k is ready when it is empty or the stage after it is ready (out_ready past the
    // last stage); unrolled, that is out_ready or any stage from k onward being empty.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_ready[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j]) begin
                    stage_ready[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready = stage_ready[0] && !rst;

    always_comb begin
        src_valid[0] = in_valid;
        src_a[0]     = a;
        src_b[0]     = sub ? ~b : b;
        src_sum[0]   = '0;
        src_carry[0] = cin ^ sub;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_carry[k] = carry_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        slice   = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
            slice = {1'b0, src_a[k][k*CHUNK +: CHUNK]} + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, src_carry[k]};
            if (stage_ready[k]) begin
                valid_d[k] = src_valid[k];
                // Data registers only load real operands so idle stages keep their last value.
                if (src_valid[k]) begin
                    a_d[k]   = src_a[k];
                    b_d[k]   = src_b[k];
                    sum_d[k] = src_sum[k];
                    sum_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
                    carry_d[k] = slice[CHUNK];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                       (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed 32/8 checks plus random traffic on 24/8 and 16/16.
module tb_pipelined_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic        in_valid0, in_ready0, cin0, sub0, out_valid0, out_ready0, cout0, ovf0;
    logic [31:0] a0, b0, sum0;
    logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [23:0] a1, b1, sum1;
    logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [15:0] a2, b2, sum2;

    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    logic [33:0] exp_q2[$];
    int          pops0 = 0;

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
        .cin(cin0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0), .sum(sum0),
        .cout(cout0), .ovf(ovf0));
    pipelined_adder #(.WIDTH(24), .CHUNK(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .ovf(ovf1));
    pipelined_adder #(.WIDTH(16), .CHUNK(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
        .cout(cout2), .ovf(ovf2));

    // Behavioural reference: returns {ovf, cout, sum} with sum zero-extended to 32 bits.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input int w);
        logic [32:0] mask;
        logic [32:0] full;
        logic [31:0] be;
        logic [31:0] am;
        logic [31:0] s;
        logic        co;
        logic        ov;
        mask = (33'd1 << w) - 33'd1;
        am   = a & mask[31:0];
        be   = (sub ? ~b : b) & mask[31:0];
        full = {1'b0, am} + {1'b0, be} + {32'd0, cin ^ sub};
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    function automatic logic [31:0] op_a(input int i);
        return 32'h0101_0101 * i + 32'h0000_00FF;
    endfunction
    function automatic logic [31:0] op_b(input int i);
        return 32'hFFFF_FF00 + i;
    endfunction
    function automatic logic op_cin(input int i);
        return (i & 1) != 0;
    endfunction
    function automatic logic op_sub(input int i);
        return (i & 2) != 0;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [32:0] mask;
        int          r;
        mask = (33'd1 << w) - 33'd1;
        r = $urandom_range(0, 7);
        if (r == 0) return mask[31:0];
        if (r == 1) return 32'd0;
        if (r == 2) return 32'd1 << (w - 1);
        if (r == 3) return (32'd1 << (w - 1)) - 32'd1;
        return $urandom & mask[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accept, pop and compare on every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q0.delete();
        end else begin
            if (out_valid0 && out_ready0) begin
                checks++;
                assert (exp_q0.size() != 0) else begin
                    failures++;
                    $error("FAIL sb0_unexpected observed=%0h expected=none", {ovf0, cout0, sum0});
                end
                if (exp_q0.size() != 0) begin
                    logic [33:0] e;
                    e = exp_q0.pop_front();
                    pops0++;
                    checks++;
                    assert ({ovf0, cout0, sum0} === e) else begin
                        failures++;
                        $error("FAIL sb0_result observed=%0h expected=%0h", {ovf0, cout0, sum0}, e);
                    end
                end
            end
            if (in_valid0 && in_ready0) exp_q0.push_back(model(a0, b0, cin0, sub0, 32));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q1.delete();
        end else begin
            if (out_valid1 && out_ready1) begin
                checks++;
                assert (exp_q1.size() != 0) else begin
                    failures++;
                    $error("FAIL sb1_unexpected observed=%0h expected=none", {ovf1, cout1, sum1});
                end
                if (exp_q1.size() != 0) begin
                    logic [33:0] e;
                    e = exp_q1.pop_front();
                    checks++;
                    assert ({ovf1, cout1, 8'd0, sum1} === e) else begin
                        failures++;
                        $error("FAIL sb1_result observed=%0h expected=%0h", {ovf1, cout1, 8'd0, sum1}, e);
                    end
                end
            end
            if (in_valid1 && in_ready1) exp_q1.push_back(model({8'd0, a1}, {8'd0, b1}, cin1, sub1, 24));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q2.delete();
        end else begin
            if (out_valid2 && out_ready2) begin
                checks++;
                assert (exp_q2.size() != 0) else begin
                    failures++;
                    $error("FAIL sb2_unexpected observed=%0h expected=none", {ovf2, cout2, sum2});
                end
                if (exp_q2.size() != 0) begin
                    logic [33:0] e;
                    e = exp_q2.pop_front();
                    checks++;
                    assert ({ovf2, cout2, 16'd0, sum2} === e) else begin
                        failures++;
                        $error("FAIL sb2_result observed=%0h expected=%0h", {ovf2, cout2, 16'd0, sum2}, e);
                    end
                end
            end
            if (in_valid2 && in_ready2) exp_q2.push_back(model({16'd0, a2}, {16'd0, b2}, cin2, sub2, 16));
        end
    end

    // One operation on the 32/8 instance with latency and result checked against constants.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] es,
                           input logic ec, input logic eo);
        a0 = a; b0 = b; cin0 = cin; sub0 = sub; in_valid0 = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready0), 64'd1);
        tick();
        in_valid0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_latency_early"}, 64'(out_valid0), 64'd0);
            tick();
        end
        check({tag, "_out_valid"}, 64'(out_valid0), 64'd1);
        check({tag, "_sum"}, 64'(sum0), 64'(es));
        check({tag, "_cout"}, 64'(cout0), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf0), 64'(eo));
        tick();
    endtask

    initial begin
        logic acc;
        logic acc1;
        logic acc2;
        int   sent;
        int   pops_start;
        logic [31:0] t;

        rst = 1'b1;
        in_valid0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; out_ready0 = 1;
        in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; out_ready1 = 1;
        in_valid2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; out_ready2 = 1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid0), 64'd0);
        check("reset_sum", 64'(sum0), 64'd0);
        check("reset_cout", 64'(cout0), 64'd0);
        check("reset_ovf", 64'(ovf0), 64'd0);
        check("reset_in_ready", 64'(in_ready0), 64'd1);

        run_one("add_carry", 32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0);
        run_one("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
        run_one("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 32'h0000_0001, 1, 0);
        run_one("sub_borrow", 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0);
        run_one("sub_cin",    32'd7, 32'd5, 1, 1, 32'h0000_0001, 1, 0);
        run_one("sub_ovf",    32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 1, 1);

        // Backpressure: ten ops streamed, downstream stalled in cycles 6..12.
        sent = 0;
        pops_start = pops0;
        for (int c = 0; c < 40; c++) begin
            out_ready0 = !(c >= 6 && c <= 12);
            if (sent < 10) begin
                in_valid0 = 1'b1;
                a0 = op_a(sent); b0 = op_b(sent); cin0 = op_cin(sent); sub0 = op_sub(sent);
            end else begin
                in_valid0 = 1'b0;
            end
            @(negedge clk);
            acc = in_valid0 && in_ready0;
            if (c == 7 || c == 9 || c == 12) begin
                check("bp_hold_valid", 64'(out_valid0), 64'd1);
                check("bp_hold_result", 64'({ovf0, cout0, sum0}),
                      64'(model(op_a(2), op_b(2), op_cin(2), op_sub(2), 32)));
            end
            if (c == 9 || c == 12) check("bp_in_ready_full", 64'(in_ready0), 64'd0);
            tick();
            if (acc) sent++;
        end
        out_ready0 = 1'b1;
        check("bp_delivered", 64'(pops0 - pops_start), 64'd10);
        check("bp_queue_empty", 64'(exp_q0.size()), 64'd0);

        // Reset mid-flight, with an operand presented during the reset cycle.
        for (int i = 0; i < 3; i++) begin
            in_valid0 = 1'b1;
            a0 = op_a(i + 20); b0 = op_b(i + 20); cin0 = 0; sub0 = 0;
            tick();
        end
        a0 = 32'hDEAD_BEEF; b0 = 32'h1234_0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid0 = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_sum", 64'(sum0), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rst_no_stale", 64'(out_valid0), 64'd0);
        end
        run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0);

        // Random traffic on the 24/8 and 16/16 instances.
        acc1 = 1'b0;
        acc2 = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            if (!in_valid1 || acc1) begin
                in_valid1 = ($urandom_range(0, 3) != 0);
                t = pick(24); a1 = t[23:0];
                t = pick(24); b1 = t[23:0];
                cin1 = 1'($urandom_range(0, 1));
                sub1 = 1'($urandom_range(0, 1));
            end
            if (!in_valid2 || acc2) begin
                in_valid2 = ($urandom_range(0, 3) != 0);
                t = pick(16); a2 = t[15:0];
                t = pick(16); b2 = t[15:0];
                cin2 = 1'($urandom_range(0, 1));
                sub2 = 1'($urandom_range(0, 1));
            end
            out_ready1 = ($urandom_range(0, 3) != 0);
            out_ready2 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc1 = in_valid1 && in_ready1;
            acc2 = in_valid2 && in_ready2;
            tick();
        end
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        out_ready1 = 1'b1; out_ready2 = 1'b1;
        for (int i = 0; i < 20 && (exp_q1.size() != 0 || exp_q2.size() != 0); i++) tick();
        tick();
        check("rand24_drained", 64'(exp_q1.size()), 64'd0);
        check("rand16_drained", 64'(exp_q2.size()), 64'd0);
        check("rand24_idle", 64'(out_valid1), 64'd0);
        check("rand16_idle", 64'(out_valid2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
